snn_image_loader: RTL and testbench

- Upstream stage of the SNN inference core.
- Collects a packed 784-pixel binary image from a byte stream (UART RX side) into an internal 1-bit-per-pixel buffer.
- Serves the core's pixel read port, pulses the core's start, and captures the classified digit when the core reports done.
- Loops continuously: one image in, one digit out.

---
 rtl/snn_image_loader.sv | 133 +++++++++++++
 tb/tb_snn_image_loader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/snn_image_loader.sv
// Image loader for the SNN core: packs a 98-byte pixel stream into a 784x1 buffer, pulses start, captures the digit.
// Latency: last byte -> start next cycle; pixel read 1 cycle; core_done -> digit/digit_vld next cycle.
// No backpressure: bytes outside LOAD are dropped. Optional SNN_LOADER_TIMEOUT_EN discards stalled partial frames.
module snn_image_loader #(
    parameter int NUM_PIXELS     = 784,
    parameter int NUM_BYTES      = 98,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic [9:0] addr_input_unit,
    output logic       q_input,
    output logic       start,
    input  logic       core_done,
    input  logic [3:0] core_digit,
    output logic [3:0] digit,
    output logic       digit_vld,
    output logic       busy
);

    typedef enum logic [1:0] {LOAD, START, WAIT, RESULT} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [6:0]  cnt;
    logic [7:0]  mem [NUM_BYTES];
    logic        wr_en;
    logic        last_byte;
    logic        timeout_hit;
    logic        rd_in_range;
    logic [6:0]  rd_idx;

    assign wr_en     = (state == LOAD) && rx_valid;
    assign last_byte = (cnt == 7'(NUM_BYTES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        busy      = 1'b0;
        digit_vld = 1'b0;
        case (state)
            LOAD: begin
                if (wr_en && last_byte) begin
                    state_nxt = START;
                end
            end
            START: begin
                start     = 1'b1;
                busy      = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (core_done) begin
                    state_nxt = RESULT;
                end
            end
            RESULT: begin
                digit_vld = 1'b1;
                state_nxt = LOAD;
            end
            default: state_nxt = LOAD;
        endcase
    end

    // The counter only wraps on the final byte, so it is already 0 outside LOAD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 7'd0;
        end else if (wr_en) begin
            cnt <= last_byte ? 7'd0 : cnt + 7'd1;
        end else if (timeout_hit) begin
            cnt <= 7'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit <= 4'd0;
        end else if ((state == WAIT) && core_done) begin
            digit <= core_digit;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[cnt] <= rx_data;
        end
    end

    // Out-of-range addresses are steered to byte 0 and masked, keeping the index in bounds.
    assign rd_in_range = (addr_input_unit < 10'(NUM_PIXELS));
    assign rd_idx      = rd_in_range ? addr_input_unit[9:3] : 7'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_input <= 1'b0;
        end else begin
            q_input <= rd_in_range & mem[rd_idx][addr_input_unit[2:0]];
        end
    end

`ifdef SNN_LOADER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] idle_cnt;

    assign timeout_hit = (idle_cnt == TO_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if ((state != LOAD) || (cnt == 7'd0) || rx_valid || timeout_hit) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_snn_image_loader.sv
// Self-checking bench for snn_image_loader: constant read table plus randomized images against a byte-array model.
module tb_snn_image_loader;

    localparam int NUM_PIXELS = 784;
    localparam int NUM_BYTES  = 98;
    localparam int TO_CYCLES  = 100;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [9:0] addr_input_unit;
    logic       q_input;
    logic       start;
    logic       core_done;
    logic [3:0] core_digit;
    logic [3:0] digit;
    logic       digit_vld;
    logic       busy;

    snn_image_loader #(
        .NUM_PIXELS    (NUM_PIXELS),
        .NUM_BYTES     (NUM_BYTES),
        .TIMEOUT_CYCLES(TO_CYCLES)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .addr_input_unit(addr_input_unit),
        .q_input        (q_input),
        .start          (start),
        .core_done      (core_done),
        .core_digit     (core_digit),
        .digit          (digit),
        .digit_vld      (digit_vld),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] addr;
        logic       exp;
    } rd_vec_t;

    int         total = 0;
    int         bad = 0;
    int         start_pulses = 0;
    int         dvld_pulses = 0;
    logic [7:0] tx_bytes [256];
    logic [7:0] img [NUM_BYTES];
    rd_vec_t    rd_tab [7];

    always @(negedge clk) begin
        if (start) start_pulses++;
        if (digit_vld) dvld_pulses++;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Streams tx_bytes[0..n-1]; reports the 1-based byte after which start was first seen (0 = never).
    task automatic send_bytes(input int n, output int first_start);
        first_start = 0;
        for (int i = 0; i < n; i++) begin
            rx_data  = tx_bytes[i];
            rx_valid = 1'b1;
            tick();
            rx_valid = 1'b0;
            if (start && first_start == 0) first_start = i + 1;
        end
    endtask

    task automatic read_pixel(input logic [9:0] a, output logic q);
        addr_input_unit = a;
        tick();
        q = q_input;
    endtask

    function automatic logic model_pixel(input int a);
        if (a >= NUM_PIXELS) return 1'b0;
        return img[a / 8][a % 8];
    endfunction

    task automatic finish_inference(input logic [3:0] d, input string tag);
        core_done  = 1'b1;
        core_digit = d;
        tick();
        core_done = 1'b0;
        check({tag, "_digit"}, int'(digit), int'(d));
        check({tag, "_dvld"}, int'(digit_vld), 1);
        check({tag, "_busy_low"}, int'(busy), 0);
        tick();
    endtask

    initial begin
        int   got;
        int   busy_drops;
        int   s0;
        int   d0;
        int   exp_to;
        logic q;

        rd_tab[0] = '{10'd0,   1'b1};
        rd_tab[1] = '{10'd1,   1'b0};
        rd_tab[2] = '{10'd2,   1'b1};
        rd_tab[3] = '{10'd7,   1'b1};
        rd_tab[4] = '{10'd783, 1'b1};
        rd_tab[5] = '{10'd800, 1'b0};
        rd_tab[6] = '{10'd1023, 1'b0};

        rst = 1'b1;
        rx_data = 8'd0;
        rx_valid = 1'b0;
        addr_input_unit = 10'd0;
        core_done = 1'b0;
        core_digit = 4'd0;
        tick();
        tick();
        check("rst_q_input", int'(q_input), 0);
        check("rst_start", int'(start), 0);
        check("rst_digit", int'(digit), 0);
        check("rst_digit_vld", int'(digit_vld), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1'b0;
        tick();

        // Image of 0xA5 bytes, start exactly after the 98th strobe.
        for (int i = 0; i < 256; i++) tx_bytes[i] = 8'hA5;
        send_bytes(NUM_BYTES, got);
        check("a5_start_at", got, NUM_BYTES);
        check("a5_busy_start", int'(busy), 1);
        tick();
        check("a5_start_one_cycle", int'(start), 0);
        check("a5_busy_wait", int'(busy), 1);

        for (int i = 0; i < 7; i++) begin
            read_pixel(rd_tab[i].addr, q);
            check($sformatf("a5_read_%0d", rd_tab[i].addr), int'(q), int'(rd_tab[i].exp));
        end

        // Bytes during WAIT must not touch the buffer.
        for (int i = 0; i < 10; i++) tx_bytes[i] = 8'hFF;
        send_bytes(10, got);
        check("wait_drop_no_start", got, 0);
        read_pixel(10'd1, q);
        check("wait_drop_addr1", int'(q), 0);
        read_pixel(10'd9, q);
        check("wait_drop_addr9", int'(q), 0);

        busy_drops = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!busy) busy_drops++;
        end
        check("wait_busy_held", busy_drops, 0);
        finish_inference(4'd7, "img_a5");
        check("rslt_dvld_one_cycle", int'(digit_vld), 0);

        core_done  = 1'b1;
        core_digit = 4'd5;
        tick();
        core_done = 1'b0;
        check("done_outside_wait_digit", int'(digit), 7);
        check("done_outside_wait_dvld", int'(digit_vld), 0);

        // Random image 1: full frame needed after RESULT, reads checked against the byte model.
        for (int i = 0; i < NUM_BYTES; i++) begin
            tx_bytes[i] = 8'($urandom);
            img[i] = tx_bytes[i];
        end
        send_bytes(NUM_BYTES, got);
        check("rnd1_start_at", got, NUM_BYTES);
        tick();
        for (int i = 0; i < 24; i++) begin
            int a;
            a = (i < 20) ? int'($urandom_range(0, NUM_PIXELS - 1)) : int'($urandom_range(0, 1023));
            read_pixel(10'(a), q);
            check($sformatf("rnd1_read_%0d", a), int'(q), int'(model_pixel(a)));
        end
        finish_inference(4'd3, "img_r1");

        // Random image 2 back-to-back; core_done collides with a byte that must be dropped.
        for (int i = 0; i < NUM_BYTES; i++) tx_bytes[i] = 8'($urandom);
        send_bytes(NUM_BYTES, got);
        check("rnd2_start_at", got, NUM_BYTES);
        tick();
        rx_data    = 8'h00;
        rx_valid   = 1'b1;
        core_done  = 1'b1;
        core_digit = 4'd9;
        tick();
        rx_valid  = 1'b0;
        core_done = 1'b0;
        check("img_r2_digit", int'(digit), 9);
        check("img_r2_dvld", int'(digit_vld), 1);
        tick();
        send_bytes(NUM_BYTES - 1, got);
        check("collide_no_early_start", got, 0);
        send_bytes(1, got);
        check("collide_start_on_98th", got, 1);
        for (int i = 0; i < 10; i++) tick();
        check("digit_holds_9", int'(digit), 9);

        // Reset mid-inference, then mid-image; only the post-reset frame may start.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_wait_busy", int'(busy), 0);
        check("rst_wait_digit", int'(digit), 0);
        send_bytes(40, got);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        s0 = start_pulses;
        d0 = dvld_pulses;
        send_bytes(NUM_BYTES, got);
        check("rst_frame_start_at", got, NUM_BYTES);
        tick();
        tick();
        check("rst_frame_start_count", start_pulses - s0, 1);
        check("rst_frame_no_dvld", dvld_pulses - d0, 0);
        check("rst_frame_digit", int'(digit), 0);
        finish_inference(4'd4, "img_rst");

        // Stalled partial frame: discarded only when the timeout feature is built in.
`ifdef SNN_LOADER_TIMEOUT_EN
        exp_to = NUM_BYTES;
`else
        exp_to = NUM_BYTES - 5;
`endif
        send_bytes(5, got);
        check("partial_no_start", got, 0);
        for (int i = 0; i < TO_CYCLES + 10; i++) tick();
        send_bytes(2 * NUM_BYTES, got);
        check("timeout_start_at", got, exp_to);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
